timer_irq_source: RTL and testbench
===================================

// Module: timer_irq_source
// PURPOSE
//  Memory-mapped 32-bit interval timer and interrupt source on the data-memory bus.
//  Raises the level IRQ that CPU_Control samples. Holds it until software clears the
//  status bit or the CPU acknowledges interrupt entry.
//  Sits beside data memory; the bus mux selects rdata when addr hits BASE_ADDR.
// PARAMETERS
//  BASE_ADDR   32'h4000_0000  base of the 16-byte register window (aligned to 16)
//  PRESCALE_W  16             width of prescaler register/counter (TIMER_PRESCALE_EN only)
// PORTS
//  clk      in   1   system clock; all state changes on rising edge
//  reset    in   1   asynchronous, active-high reset
//  addr     in   32  byte address from ALU result; addr[1:0] ignored
//  wdata    in   32  store data
//  MemRd    in   1   load strobe
//  MemWr    in   1   store strobe
//  irq_ack  in   1   one-cycle pulse: CPU took the interrupt (Interrupt asserted)
//  rdata    out  32  read data; combinational
//  IRQ      out  1   level interrupt request = TCON[1] & TCON[2]; registered
// BEHAVIOUR
//  Decode: hit = (addr[31:4]==BASE_ADDR[31:4]); offset = addr[3:2].
//   0:TH reload value, 1:TL counter, 2:TCON, 3:TPRE (or reserved).
//  TCON bit0 EN: counting enabled.
//  TCON bit1 IE: interrupt enable.
//  TCON bit2 ST: status, sticky; bits 31:3 read 0, writes ignored.
//  Reset: TH=0, TL=0, TCON=0, prescaler=0, IRQ=0; rdata follows decode (0).
//  Reads: rdata = register when hit&MemRd, else 32'h0; zero latency, no side effects.
//  Writes: take effect at the clk edge where hit&MemWr; value readable next cycle.
//  Tick: a cycle where EN=1 (and prescaler expired, see CONFIGURATION).
//  On tick:
//   - TL!=32'hFFFF_FFFF: TL<=TL+1.
//   - TL==32'hFFFF_FFFF: TL<=TH (reload); ST<=1 if IE=1.
//  ST is unchanged when IE=0.
//  Priority, same cycle:
//   - TL write beats tick (written value lands, no increment).
//   - TH write plus overflow: reload uses the OLD TH.
//   - ST: hardware set beats software clear (TCON write with bit2=0) and irq_ack;
//     no interrupt is ever lost.
//   - TCON write with EN=0: that cycle's tick is still suppressed, because EN comes
//     from the written value.
//  irq_ack clears ST (unless a set happens that cycle). It is ignored when ST=0.
//  IRQ registered: IRQ(t+1) = IE(t+1)&ST(t+1). It is asserted 1 cycle after the
//   overflow edge and dropped 1 cycle after a clear/ack.
//  Clearing IE masks IRQ but keeps ST; setting IE again re-asserts IRQ.
//  TH=32'hFFFF_FFFF gives an overflow every tick.
//  Reset mid-count: immediate async clear; no pending state survives.
// CONFIGURATION
//  TIMER_PRESCALE_EN defined:
//   - Offset 3 = TPRE[PRESCALE_W-1:0], reset 0.
//   - Tick fires once every TPRE+1 enabled cycles; internal prescale count reloads on
//     tick and on any TPRE write; it holds when EN=0.
//  Not defined: tick on every enabled cycle; offset 3 reads 0, writes ignored.
// STRUCTURE
//  timer_pkg: offsets (TH_OFF=2'd0, TL_OFF=2'd1, TCON_OFF=2'd2, TPRE_OFF=2'd3),
//   TCON bit indices (TCON_EN=0, TCON_IE=1, TCON_ST=2), TL_MAX constant.
//  Sub-module timer_prescaler (inside `ifdef TIMER_PRESCALE_EN): en, load, div -> tick.
//  Top keeps decode, register file, overflow/ST priority logic and IRQ flop.
// TESTING
//  1. TH=FFFF_FFF0, TL=FFFF_FFFE, TCON=3 -> IRQ=1 2 cycles later;
//     TL reads FFFF_FFF0 after the overflow.
//  2. IRQ high, irq_ack pulse -> IRQ=0 next cycle; TCON reads 3.
//  3. irq_ack or TCON write of 3 on the overflow cycle -> ST stays 1, IRQ stays 1.
//  4. TCON=1 (IE=0), overflow -> ST=0, IRQ=0; later TCON=3 -> IRQ stays 0.
//     Repeat with ST set first and IE toggled 0->1 -> IRQ re-asserts.
//  5. TL write of 5 in a tick cycle -> TL reads 5 (not 6); read of 0x4000_0010 -> 0.
//  6. TIMER_PRESCALE_EN, TPRE=3, TCON=1 -> TL +1 every 4 cycles;
//     reset mid-count -> all regs 0, IRQ=0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants for the memory-mapped interval timer: register offsets,
// TCON bit positions and the counter overflow value.
package timer_pkg;

    localparam int unsigned DATA_W = 32;

    // Word offsets inside the 16-byte register window (addr[3:2])
    localparam logic [1:0] TH_OFF   = 2'd0;
    localparam logic [1:0] TL_OFF   = 2'd1;
    localparam logic [1:0] TCON_OFF = 2'd2;
    localparam logic [1:0] TPRE_OFF = 2'd3;

    // TCON bit indices
    localparam int unsigned TCON_EN = 0;
    localparam int unsigned TCON_IE = 1;
    localparam int unsigned TCON_ST = 2;

    // Counter value at which the next tick reloads from TH
    localparam logic [DATA_W-1:0] TL_MAX = 32'hFFFF_FFFF;

    // Architectural TCON contents; bits 31:3 are not stored
    typedef struct packed {
        logic st;
        logic ie;
        logic en;
    } tcon_t;

    // Zero-extend TCON to a bus word for reads
    function automatic logic [DATA_W-1:0] tcon_word(input tcon_t t);
        return DATA_W'({t.st, t.ie, t.en});
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Tick divider for the interval timer: fires tick_c once every div_i+1 enabled
// cycles. The count restarts on every tick and whenever load_i signals a
// divider write, and simply holds while en_i is low.
module timer_prescaler #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] div_i,
    output logic         tick_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // A divider write restarts the period, so no tick is issued in that cycle
    assign tick_c = en_i & ~load_i & (cnt_q == div_i);

    // Next count: restart on load or tick, advance on enabled cycles
    always_comb begin
        cnt_d = cnt_q;
        if (load_i || tick_c) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_irq_source.sv
// Memory-mapped 32-bit interval timer with a level interrupt output.
// Registers: TH (reload), TL (counter), TCON {ST,IE,EN}, TPRE (prescaler).
// Optional feature macro TIMER_PRESCALE_EN adds the TPRE register and the
// tick divider; without it the timer ticks every enabled cycle and offset 3
// reads as zero.
module timer_irq_source
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic        irq_ack,
    output logic [31:0] rdata,
    output logic        IRQ
);

    logic [DATA_W-1:0] th_q, th_d;
    logic [DATA_W-1:0] tl_q, tl_d;
    tcon_t             tcon_q, tcon_d;
    logic              irq_q, irq_d;

    logic              hit_c;
    logic [1:0]        off_c;
    logic              wr_th_c, wr_tl_c, wr_tcon_c, wr_tpre_c;
    logic              en_eff_c, ie_eff_c;
    logic              tick_c, ovf_c;
    logic [DATA_W-1:0] tpre_word_c;

    // Byte lane bits carry no meaning on this word-only window
    logic [1:0]        unused_addr;
    assign unused_addr = addr[1:0];

    // Address decode and per-register write strobes
    assign hit_c     = (addr[31:4] == BASE_ADDR[31:4]);
    assign off_c     = addr[3:2];
    assign wr_th_c   = hit_c & MemWr & (off_c == TH_OFF);
    assign wr_tl_c   = hit_c & MemWr & (off_c == TL_OFF);
    assign wr_tcon_c = hit_c & MemWr & (off_c == TCON_OFF);
    assign wr_tpre_c = hit_c & MemWr & (off_c == TPRE_OFF);

    // A TCON write governs this cycle's counting and interrupt enable
    assign en_eff_c = wr_tcon_c ? wdata[TCON_EN] : tcon_q.en;
    assign ie_eff_c = wr_tcon_c ? wdata[TCON_IE] : tcon_q.ie;

`ifdef TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] tpre_q, tpre_d;

    // Prescaler register write
    always_comb begin
        tpre_d = tpre_q;
        if (wr_tpre_c) begin
            tpre_d = wdata[PRESCALE_W-1:0];
        end
    end

    // Prescaler register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tpre_q <= '0;
        end else begin
            tpre_q <= tpre_d;
        end
    end

    timer_prescaler #(
        .W (PRESCALE_W)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .en_i   (en_eff_c),
        .load_i (wr_tpre_c),
        .div_i  (tpre_q),
        .tick_c (tick_c)
    );

    assign tpre_word_c = DATA_W'(tpre_q);
`else
    localparam int unsigned unused_prescale_w = PRESCALE_W;
    logic                   unused_wr_tpre;

    assign unused_wr_tpre = wr_tpre_c;
    assign tick_c         = en_eff_c;
    assign tpre_word_c    = '0;
`endif

    // An overflow only happens when software is not overwriting TL this cycle
    assign ovf_c = tick_c & ~wr_tl_c & (tl_q == TL_MAX);

    // Register file next state with write/tick/status priorities
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;

        if (wr_th_c) begin
            th_d = wdata;
        end

        // Reload uses the TH value held before any same-cycle TH write
        if (wr_tl_c) begin
            tl_d = wdata;
        end else if (tick_c) begin
            tl_d = (tl_q == TL_MAX) ? th_q : tl_q + DATA_W'(1);
        end

        tcon_d.en = en_eff_c;
        tcon_d.ie = ie_eff_c;

        // Hardware set outranks software write and acknowledge
        if (ovf_c && ie_eff_c) begin
            tcon_d.st = 1'b1;
        end else if (wr_tcon_c) begin
            tcon_d.st = wdata[TCON_ST];
        end else if (irq_ack) begin
            tcon_d.st = 1'b0;
        end

        irq_d = tcon_d.ie & tcon_d.st;
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            irq_q  <= irq_d;
        end
    end

    // Zero-latency read mux; idle bus reads zero
    always_comb begin
        rdata = '0;
        if (hit_c && MemRd) begin
            unique case (off_c)
                TH_OFF:   rdata = th_q;
                TL_OFF:   rdata = tl_q;
                TCON_OFF: rdata = tcon_word(tcon_q);
                default:  rdata = tpre_word_c;
            endcase
        end
    end

    assign IRQ = irq_q;

endmodule

// File: tb/tb_timer_irq_source.sv
// Self-checking bench for timer_irq_source: directed scenarios followed by
// randomized bus traffic, all compared against a behavioural register model.
module tb_timer_irq_source;

    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam logic [31:0] MAXV   = 32'hFFFF_FFFF;
    localparam int unsigned PRE_W  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        MemRd;
    logic        MemWr;
    logic        irq_ack;
    logic [31:0] rdata;
    logic        IRQ;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_th, m_tl;
    logic        m_en, m_ie, m_st, m_irq;
    int          m_pre, m_since;

    timer_irq_source #(
        .BASE_ADDR  (BASE),
        .PRESCALE_W (PRE_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .wdata   (wdata),
        .MemRd   (MemRd),
        .MemWr   (MemWr),
        .irq_ack (irq_ack),
        .rdata   (rdata),
        .IRQ     (IRQ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_th = '0; m_tl = '0; m_en = 0; m_ie = 0; m_st = 0; m_irq = 0;
        m_pre = 0; m_since = 0;
    endtask

    function automatic logic [31:0] model_read();
        if (addr[31:4] != BASE[31:4] || !MemRd) return '0;
        case (addr[3:2])
            2'd0:    return m_th;
            2'd1:    return m_tl;
            2'd2:    return {29'd0, m_st, m_ie, m_en};
            default: return 32'(m_pre);
        endcase
    endfunction

    // Apply the timer rules for one clock edge using the current bus inputs
    task automatic model_update();
        logic       hit, w_th, w_tl, w_tc, w_pre, en_now, ie_now, tick, wrap;
        logic [31:0] old_th;
        hit    = (addr[31:4] == BASE[31:4]) && MemWr;
        w_th   = hit && addr[3:2] == 2'd0;
        w_tl   = hit && addr[3:2] == 2'd1;
        w_tc   = hit && addr[3:2] == 2'd2;
        w_pre  = hit && addr[3:2] == 2'd3;
        en_now = w_tc ? wdata[0] : m_en;
        ie_now = w_tc ? wdata[1] : m_ie;
`ifdef TIMER_PRESCALE_EN
        // Count enabled cycles; the (TPRE+1)-th one is a tick
        if (w_pre) begin
            tick    = 0;
            m_since = 0;
            m_pre   = int'(wdata[PRE_W-1:0]);
        end else if (en_now) begin
            tick    = (m_since == m_pre);
            m_since = tick ? 0 : m_since + 1;
        end else begin
            tick = 0;
        end
`else
        tick = en_now;
        if (w_pre) m_pre = 0;
`endif
        old_th = m_th;
        wrap   = tick && !w_tl && m_tl == MAXV;
        if (w_tl)      m_tl = wdata;
        else if (wrap) m_tl = old_th;
        else if (tick) m_tl = m_tl + 1;
        if (w_th) m_th = wdata;
        if (wrap && ie_now) m_st = 1;
        else if (w_tc)      m_st = wdata[2];
        else if (irq_ack)   m_st = 0;
        m_en  = en_now;
        m_ie  = ie_now;
        m_irq = m_ie & m_st;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] wd,
                         input logic rd, input logic wr, input logic ack);
        addr = a; wdata = wd; MemRd = rd; MemWr = wr; irq_ack = ack;
        #1;
    endtask

    // Compare this cycle's outputs with the model, then advance one clock
    task automatic step();
        check("rdata", rdata, model_read());
        check("irq", 32'(IRQ), 32'(m_irq));
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic wr_reg(input int off, input logic [31:0] v);
        drive(BASE + 32'(off * 4), v, 1'b0, 1'b1, 1'b0);
        step();
    endtask

    task automatic rd_reg(input int off);
        drive(BASE + 32'(off * 4), 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle();
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    // Async reset in mid-cycle; every register must read zero immediately
    task automatic mid_reset(input string tag);
        #1 reset = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            rd_reg(i);
            check({tag, "_reg"}, rdata, 32'h0);
        end
        check({tag, "_irq"}, 32'(IRQ), 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rd_reg(i);
            check("reset_reg", rdata, 32'h0);
        end
        check("reset_irq", 32'(IRQ), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Overflow raises IRQ two cycles after enabling; TL reloads from TH
        wr_reg(0, 32'hFFFF_FFF0);
        wr_reg(1, 32'hFFFF_FFFE);
        wr_reg(2, 32'h3);
        check("t1_irq_early", 32'(IRQ), 32'h0);
        idle();
        rd_reg(1);
        check("t1_irq", 32'(IRQ), 32'h1);
        check("t1_reload", rdata, 32'hFFFF_FFF0);
        step();

        // Acknowledge drops IRQ next cycle and clears only ST
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        rd_reg(2);
        check("t2_irq", 32'(IRQ), 32'h0);
        check("t2_tcon", rdata, 32'h3);
        step();

        // Set on the overflow cycle beats acknowledge and software clear
        wr_reg(1, MAXV);
        idle();
        wr_reg(1, MAXV);
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        rd_reg(2);
        check("t3_ack_irq", 32'(IRQ), 32'h1);
        check("t3_ack_tcon", rdata, 32'h7);
        step();
        wr_reg(1, MAXV);
        wr_reg(2, 32'h3);
        rd_reg(2);
        check("t3_wr_irq", 32'(IRQ), 32'h1);
        check("t3_wr_tcon", rdata, 32'h7);
        step();

        // IE=0 overflow leaves ST clear; masking keeps a pending ST
        wr_reg(2, 32'h1);
        wr_reg(1, MAXV);
        idle();
        rd_reg(2);
        check("t4_masked_tcon", rdata, 32'h1);
        step();
        wr_reg(2, 32'h3);
        rd_reg(2);
        check("t4_noirq", 32'(IRQ), 32'h0);
        step();
        wr_reg(1, MAXV);
        idle();
        check("t4_set_irq", 32'(IRQ), 32'h1);
        wr_reg(2, 32'h5);
        rd_reg(2);
        check("t4_mask_irq", 32'(IRQ), 32'h0);
        check("t4_mask_tcon", rdata, 32'h5);
        step();
        wr_reg(2, 32'h7);
        check("t4_unmask_irq", 32'(IRQ), 32'h1);

        // TL write beats the tick; out-of-window read returns zero
        wr_reg(2, 32'h1);
        wr_reg(1, 32'h5);
        rd_reg(1);
        check("t5_tl_write", rdata, 32'h5);
        step();
        drive(BASE + 32'h10, 32'h0, 1'b1, 1'b0, 1'b0);
        check("t5_outside", rdata, 32'h0);
        step();
        rd_reg(3);
`ifndef TIMER_PRESCALE_EN
        check("t5_tpre_absent", rdata, 32'h0);
`endif
        step();

`ifdef TIMER_PRESCALE_EN
        // TPRE=3: TL advances once every four enabled cycles
        wr_reg(2, 32'h0);
        wr_reg(1, 32'h0);
        wr_reg(3, 32'h3);
        wr_reg(2, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            rd_reg(1);
            check("t6_prescale", rdata, 32'(k / 4));
            step();
        end
`endif
        mid_reset("t6_reset");

        // Randomized bus traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a, wd;
            int          sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 8)       a = BASE + 32'($urandom_range(0, 15));
            else if (sel == 8) a = BASE + 32'h10 + 32'($urandom_range(0, 15));
            else               a = $urandom;
            case (a[3:2])
                2'd1:    wd = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
                2'd3:    wd = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
                default: wd = $urandom;
            endcase
            if (a[3:2] == 2'd2 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
            drive(a, wd, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) == 0);
            step();
            if (n == 1500) mid_reset("rand_reset");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
